serial_adder: RTL and testbench

//   Bit-serial N-bit adder. Operands are loaded in parallel, then summed LSB-first.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_fa_bit.sv | 23 ++
 rtl/serial_adder.sv | 96 +++++++++
 tb/tb_serial_adder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared FSM encodings and widths for the bit-serial adder.
// Optional subtract mode is controlled by SERIAL_ADDER_SUB_EN (see serial_adder.sv).
package serial_adder_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full-adder slice: two half-adder cells plus an OR.
// Purely combinational; the carry is registered by the parent.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;

    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;

    assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder slice.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a-b mode).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam int SW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [SW-1:0]    sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic s_bit;
    logic c_nxt;

    fa_bit u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry),
        .s    (s_bit),
        .cout (c_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_sr <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_reg <= a;
`ifdef SERIAL_ADDER_SUB_EN
                        b_reg <= sub ? ~b : b;
                        carry <= sub;
`else
                        b_reg <= b;
                        carry <= 1'b0;
`endif
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    carry  <= c_nxt;
                    cnt    <= cnt + 1'b1;
                    sum_sr <= SW'({s_bit, sum_sr} >> 1);
                    // Output regs load only on the last bit, so partials stay hidden.
                    if (cnt == LAST) begin
                        sum   <= {s_bit, sum_sr};
                        cout  <= c_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif

    int asserts  = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; lat = edges from accept to done, -1 on timeout.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic sv, output int lat,
                         output int busy_n);
        start = 1'b1;
        a = av;
        b = bv;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sv;
`else
        if (sv) $display("note: sub ignored in add-only build");
`endif
        tick();
        start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        tick();
        tick();
        asserts++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int lat;
        int bn;
        do_op(8'h3C, 8'h0F, 1'b0, lat, bn);
        asserts++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL latency: got %0d want 8", lat);
        end
        asserts++;
        if (bn !== 8) begin
            failures++;
            $display("FAIL busy_cycles: got %0d want 8", bn);
        end
        asserts++;
        if (sum !== 8'h4B || cout !== 1'b0) begin
            failures++;
            $display("FAIL add_3c_0f: sum=%h cout=%b want 4b/0", sum, cout);
        end
        tick();
        asserts++;
        if (done !== 1'b0 || sum !== 8'h4B) begin
            failures++;
            $display("FAIL done_pulse: done=%b sum=%h want 0/4b", done, sum);
        end
        do_op(8'hFF, 8'h01, 1'b0, lat, bn);
        asserts++;
        if (lat !== 8 || sum !== 8'h00 || cout !== 1'b1) begin
            failures++;
            $display("FAIL add_ff_01: lat=%0d sum=%h cout=%b want 8/00/1",
                     lat, sum, cout);
        end
        tick();
        do_op(8'h00, 8'h00, 1'b0, lat, bn);
        asserts++;
        if (lat !== 8 || sum !== 8'h00 || cout !== 1'b0) begin
            failures++;
            $display("FAIL add_00_00: lat=%0d sum=%h cout=%b want 8/00/0",
                     lat, sum, cout);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int lat;
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        asserts++;
        if (lat !== 8 || sum !== 8'h30 || cout !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start: lat=%0d sum=%h cout=%b want 8/30/0",
                     lat, sum, cout);
        end
        tick();
        asserts++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after: busy=%b want 0", busy);
        end
    endtask

    task automatic test_rst_mid();
        int seen;
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        asserts++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            failures++;
            $display("FAIL rst_mid: busy=%b done=%b sum=%h cout=%b want 0",
                     busy, done, sum, cout);
        end
        rst = 1'b0;
        start = 1'b0;
        seen = 0;
        repeat (12) begin
            tick();
            if (done || busy) seen++;
        end
        asserts++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_no_done: active cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int unstable;
        start = 1'b1;
        a = 8'h01;
        b = 8'h02;
        tick();
        start = 1'b0;
        repeat (7) tick();
        start = 1'b1;
        a = 8'h80;
        b = 8'h80;
        tick();
        asserts++;
        if (done !== 1'b1 || sum !== 8'h03 || cout !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: done=%b sum=%h cout=%b want 1/03/0",
                     done, sum, cout);
        end
        tick();
        start = 1'b0;
        lat = 1;
        unstable = 0;
        while (!done && lat < 40) begin
            if (sum !== 8'h03) unstable++;
            tick();
            lat++;
        end
        asserts++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d want 9", lat);
        end
        asserts++;
        if (unstable !== 0) begin
            failures++;
            $display("FAIL b2b_hold: unstable cycles=%0d want 0", unstable);
        end
        asserts++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
            failures++;
            $display("FAIL add_80_80: sum=%h cout=%b want 00/1", sum, cout);
        end
        tick();
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int lat;
        int bn;
        do_op(8'h05, 8'h07, 1'b1, lat, bn);
        asserts++;
        if (lat !== 8 || sum !== 8'hFE || cout !== 1'b0) begin
            failures++;
            $display("FAIL sub_05_07: lat=%0d sum=%h cout=%b want 8/fe/0",
                     lat, sum, cout);
        end
        tick();
        do_op(8'h07, 8'h05, 1'b1, lat, bn);
        asserts++;
        if (lat !== 8 || sum !== 8'h02 || cout !== 1'b1) begin
            failures++;
            $display("FAIL sub_07_05: lat=%0d sum=%h cout=%b want 8/02/1",
                     lat, sum, cout);
        end
        tick();
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_ignore_start();
        test_rst_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, failures);
        $finish;
    end

endmodule
